// File: rtl/vga_frame_sampler_if.sv
// rtl/vga_frame_sampler_if.sv - video input and recovered-timing/cell-sample signals of vga_frame_sampler
interface vga_frame_sampler_if;
    logic        pix_en;
    logic        hsync;
    logic        vsync;
    logic        nblanc;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        locked;
    logic        cell_we;
    logic [3:0]  cell_idx;
    logic [23:0] cell_rgb;
    logic        frame_done;
    logic        err;
    logic [15:0] frame_crc;

    modport master (
        output pix_en, hsync, vsync, nblanc, r, g, b,
        input  x, y, locked, cell_we, cell_idx, cell_rgb, frame_done, err, frame_crc
    );

    modport slave (
        input  pix_en, hsync, vsync, nblanc, r, g, b,
        output x, y, locked, cell_we, cell_idx, cell_rgb, frame_done, err, frame_crc
    );
endinterface

// File: rtl/vga_frame_sampler.sv
// rtl/vga_frame_sampler.sv - VGA timing lock and 4x4 cell-centre sampler; VGA_FRAME_SAMPLER_CRC_EN adds a per-frame CRC-16
module vga_frame_sampler #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int GRID_X0     = 160,
    parameter int GRID_Y0     = 80,
    parameter int CELL_W      = 80,
    parameter int CELL_H      = 80,
    parameter int LOCK_FRAMES = 2
) (
    input logic               clk,
    input logic               reset,
    vga_frame_sampler_if.slave bus
);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [9:0]  H_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  V_N    = 10'(V_ACTIVE);
    localparam logic [9:0]  Y_MAX  = 10'(V_ACTIVE - 1);
    localparam logic [GW:0] LOCK_N = (GW + 1)'(LOCK_FRAMES);
    localparam logic [GW:0] GC_ONE = (GW + 1)'(1);

    typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;

    state_t          state, state_next;
    logic            prev_vsync, prev_nblanc;
    logic [9:0]      x_q, y_q, line_cnt;
    logic            frame_bad;
    logic [GW-1:0]   good_cnt, gc_next;
    logic [15:0]     mask, mask_d;
    logic            cell_we_q, done_q, err_q, done_next, err_next;
    logic [3:0]      idx_q;
    logic [23:0]     rgb_q;

    logic            vs_fall, nb_rise, nb_fall, act, x_max, ovf, hs_viol;
    logic            line_len_bad, bad_line, good_line_end, frame_good;
    logic [9:0]      pix_x, pix_y, line_inc, lines_eff;
    logic [GW:0]     gc_inc;
    logic            col_any, row_any, hit;
    logic [1:0]      col_sel, row_sel;
    logic [23:0]     pix_rgb;

    assign pix_rgb  = {bus.r, bus.g, bus.b};
    assign vs_fall  = bus.pix_en & prev_vsync & ~bus.vsync;
    assign nb_rise  = bus.pix_en & ~prev_nblanc & bus.nblanc;
    assign nb_fall  = bus.pix_en & prev_nblanc & ~bus.nblanc;
    assign act      = bus.pix_en & bus.nblanc;
    assign x_max    = (x_q == 10'h3FF);
    assign ovf      = act & ~nb_rise & x_max;
    // An hsync pulse inside active video can only come from broken timing.
    assign hs_viol  = act & ~bus.hsync;
    assign pix_x    = nb_rise ? 10'd0 : (x_max ? x_q : x_q + 10'd1);
    assign pix_y    = vs_fall ? 10'd0 : y_q;

    assign line_len_bad  = nb_fall & (x_q != H_LAST);
    assign bad_line      = ovf | hs_viol | line_len_bad;
    assign good_line_end = nb_fall & ~line_len_bad;
    assign line_inc      = (line_cnt == 10'h3FF) ? line_cnt : line_cnt + 10'd1;
    // A line ending on the same pixel as vsync falls still belongs to the ending frame.
    assign lines_eff     = good_line_end ? line_inc : line_cnt;
    assign frame_good    = ~frame_bad & ~bad_line & (lines_eff == V_N);
    assign gc_inc        = {1'b0, good_cnt} + GC_ONE;

    always_comb begin
        col_any = 1'b0;
        row_any = 1'b0;
        col_sel = 2'd0;
        row_sel = 2'd0;
        for (int c = 0; c < 4; c++) begin
            if (pix_x == 10'(GRID_X0 + c * CELL_W + CELL_W / 2)) begin
                col_any = 1'b1;
                col_sel = 2'(c);
            end
            if (pix_y == 10'(GRID_Y0 + c * CELL_H + CELL_H / 2)) begin
                row_any = 1'b1;
                row_sel = 2'(c);
            end
        end
        hit = act & (state == LOCK) & col_any & row_any;
    end

    always_comb begin
        state_next = state;
        gc_next    = good_cnt;
        err_next   = 1'b0;
        done_next  = 1'b0;
        case (state)
            HUNT: begin
                if (vs_fall) begin
                    state_next = SYNC;
                    gc_next    = '0;
                end
            end
            SYNC: begin
                if (vs_fall) begin
                    if (frame_good) begin
                        gc_next = gc_inc[GW-1:0];
                        if (gc_inc == LOCK_N)
                            state_next = LOCK;
                    end else begin
                        gc_next  = '0;
                        err_next = 1'b1;
                    end
                end
            end
            LOCK: begin
                if (bad_line || (vs_fall && !frame_good)) begin
                    state_next = HUNT;
                    err_next   = 1'b1;
                end else if (vs_fall && (mask == 16'hFFFF)) begin
                    done_next = 1'b1;
                end
            end
            default: state_next = HUNT;
        endcase

        mask_d = (vs_fall || state_next != LOCK) ? 16'h0000 : mask;
        if (hit && state_next == LOCK)
            mask_d[{row_sel, col_sel}] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            good_cnt    <= '0;
            mask        <= '0;
            prev_vsync  <= 1'b0;
            prev_nblanc <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            line_cnt    <= '0;
            frame_bad   <= 1'b0;
            cell_we_q   <= 1'b0;
            idx_q       <= '0;
            rgb_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state     <= state_next;
            good_cnt  <= gc_next;
            mask      <= mask_d;
            err_q     <= err_next;
            done_q    <= done_next;
            cell_we_q <= hit;
            if (hit) begin
                idx_q <= {row_sel, col_sel};
                rgb_q <= pix_rgb;
            end
            if (bus.pix_en) begin
                prev_vsync  <= bus.vsync;
                prev_nblanc <= bus.nblanc;
            end
            if (act)
                x_q <= pix_x;
            if (vs_fall) begin
                y_q       <= '0;
                line_cnt  <= '0;
                frame_bad <= 1'b0;
            end else begin
                if (good_line_end) begin
                    line_cnt <= line_inc;
                    y_q      <= (y_q == Y_MAX) ? y_q : y_q + 10'd1;
                end
                if (bad_line)
                    frame_bad <= 1'b1;
            end
        end
    end

`ifdef VGA_FRAME_SAMPLER_CRC_EN
    logic [15:0] crc_acc, crc_q, crc_seed;

    function automatic logic [15:0] crc16_rgb(input logic [15:0] crc_in, input logic [23:0] d);
        logic [15:0] c;
        c = crc_in;
        for (int i = 23; i >= 0; i--)
            c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction

    assign crc_seed = vs_fall ? 16'hFFFF : crc_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_acc <= 16'hFFFF;
            crc_q   <= '0;
        end else begin
            if (act)
                crc_acc <= crc16_rgb(crc_seed, pix_rgb);
            else if (vs_fall)
                crc_acc <= 16'hFFFF;
            if (vs_fall && state == LOCK)
                crc_q <= crc_acc;
        end
    end

    assign bus.frame_crc = crc_q;
`else
    assign bus.frame_crc = 16'h0000;
`endif

    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.locked     = (state == LOCK);
    assign bus.cell_we    = cell_we_q;
    assign bus.cell_idx   = idx_q;
    assign bus.cell_rgb   = rgb_q;
    assign bus.frame_done = done_q;
    assign bus.err        = err_q;
endmodule
